// File: rtl/segre_pkg.sv
// Shared types for the segre cache/memory subsystem: request format, cache ids,
// arbiter FIFO sizing and arbiter FSM states.
package segre_pkg;

   localparam int unsigned ADDR_SIZE            = 32;
   localparam int unsigned CACHE_LINE_SIZE_BITS = 128;
   localparam int unsigned ARB_BUF_SIZE         = 16;
   localparam int unsigned ARB_PTR_SIZE         = $clog2(ARB_BUF_SIZE);

   typedef enum logic {
      ICACHE = 1'b0,
      DCACHE = 1'b1
   } cache_id_e;

   typedef struct packed {
      logic [ADDR_SIZE-1:0]            addr;
      logic                            rd;
      logic                            wr;
      logic [CACHE_LINE_SIZE_BITS-1:0] data;
      cache_id_e                       cache_id;
   } cache_mem_req_t;

   typedef enum logic {
      ARB_IDLE     = 1'b0,
      ARB_WAIT_RSP = 1'b1
   } arb_state_e;

   // Tag a request with the cache it came from, whatever the cache put there.
   function automatic cache_mem_req_t set_cache_id(input cache_mem_req_t req, input cache_id_e id);
      cache_mem_req_t r;
      r          = req;
      r.cache_id = id;
      return r;
   endfunction

endpackage

// File: rtl/segre_arb_fifo.sv
// Dual-write, single-read circular buffer for the memory arbiter. Port A is
// written at wr_ptr and port B right behind it when both push in one cycle.
module segre_arb_fifo
   import segre_pkg::*;
#(
   parameter int unsigned BUF_SIZE = ARB_BUF_SIZE,
   parameter int unsigned PTR_SIZE = ARB_PTR_SIZE
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_push_a,
   input  cache_mem_req_t      i_data_a,
   input  logic                i_push_b,
   input  cache_mem_req_t      i_data_b,
   input  logic                i_pop,
   output cache_mem_req_t      o_head,
   output logic [PTR_SIZE:0]   o_count,
   output logic                o_full,
   output logic                o_empty
);

   localparam int unsigned CNT_W = PTR_SIZE + 1;

   cache_mem_req_t      r_mem [BUF_SIZE];
   logic [PTR_SIZE-1:0] r_wr_ptr;
   logic [PTR_SIZE-1:0] r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic                r_full;
   logic                r_empty;
   logic [PTR_SIZE-1:0] w_wr_ptr_b;
   logic [CNT_W-1:0]    w_count_next;

   always_comb begin
      w_wr_ptr_b   = r_wr_ptr + PTR_SIZE'(i_push_a);
      w_count_next = r_count + CNT_W'(i_push_a) + CNT_W'(i_push_b) - CNT_W'(i_pop);
   end

   always_ff @(posedge i_clk) begin
      if (i_push_a) begin
         r_mem[r_wr_ptr] <= i_data_a;
      end
      if (i_push_b) begin
         r_mem[w_wr_ptr_b] <= i_data_b;
      end
   end

   // Flags are registered from the next count so they stay glitch-free outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= {PTR_SIZE{1'b0}};
         r_rd_ptr <= {PTR_SIZE{1'b0}};
         r_count  <= {CNT_W{1'b0}};
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         r_wr_ptr <= r_wr_ptr + PTR_SIZE'(i_push_a) + PTR_SIZE'(i_push_b);
         r_rd_ptr <= r_rd_ptr + PTR_SIZE'(i_pop);
         r_count  <= w_count_next;
         r_full   <= (w_count_next == CNT_W'(BUF_SIZE));
         r_empty  <= (w_count_next == {CNT_W{1'b0}});
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/segre_mem_arbiter_chk.sv
// Protocol checks for the memory arbiter: responses only while waiting for one,
// and a stalled memory request must not change.
module segre_mem_arbiter_chk
   import segre_pkg::*;
(
   input logic           i_clk,
   input logic           i_rst,
   input arb_state_e     i_state,
   input logic           i_mem_rsp_valid,
   input logic           i_mem_req_valid,
   input logic           i_mem_req_ready,
   input cache_mem_req_t i_mem_req
);

   a_no_rsp_in_idle: assert property (@(posedge i_clk) disable iff (i_rst)
      i_mem_rsp_valid |-> (i_state == ARB_WAIT_RSP))
      else $error("mem_rsp_valid_i while arbiter idle");

   a_req_stable: assert property (@(posedge i_clk) disable iff (i_rst)
      (i_mem_req_valid && !i_mem_req_ready) |=> $stable(i_mem_req))
      else $error("mem_req_o changed while stalled");

endmodule

// File: rtl/segre_mem_arbiter.sv
// icache/dcache to main-memory arbiter: one in-order FIFO, one outstanding
// transaction, dcache wins ties. Optional counters under SEGRE_ARB_STATS_EN.
module segre_mem_arbiter
   import segre_pkg::*;
#(
   parameter int unsigned BUF_SIZE = ARB_BUF_SIZE,
   parameter int unsigned PTR_SIZE = ARB_PTR_SIZE
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            icache_req_valid_i,
   input  cache_mem_req_t                  icache_req_i,
   output logic                            icache_req_ready_o,
   input  logic                            dcache_req_valid_i,
   input  cache_mem_req_t                  dcache_req_i,
   output logic                            dcache_req_ready_o,
   output logic                            mem_req_valid_o,
   output cache_mem_req_t                  mem_req_o,
   input  logic                            mem_req_ready_i,
   input  logic                            mem_rsp_valid_i,
   input  logic [CACHE_LINE_SIZE_BITS-1:0] mem_rsp_line_i,
   output logic                            icache_rsp_valid_o,
   output logic                            dcache_rsp_valid_o,
   output logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line_o,
   output logic                            full_o,
   output logic                            empty_o
`ifdef SEGRE_ARB_STATS_EN
   ,
   output logic [31:0]                     stat_icache_reqs_o,
   output logic [31:0]                     stat_dcache_reqs_o,
   output logic [31:0]                     stat_full_cycles_o
`endif
);

   localparam int unsigned CNT_W = PTR_SIZE + 1;

   logic [CNT_W-1:0]                w_count;
   logic                            w_full;
   logic                            w_empty;
   cache_mem_req_t                  w_head;
   cache_mem_req_t                  w_i_entry;
   cache_mem_req_t                  w_d_entry;
   logic                            w_i_push;
   logic                            w_d_push;
   logic                            w_pop;
   logic                            w_rsp_fire;
   logic                            w_mem_req_valid;
   arb_state_e                      w_state_next;
   arb_state_e                      r_state;
   cache_id_e                       r_owner;
   logic                            r_icache_rsp_valid;
   logic                            r_dcache_rsp_valid;
   logic [CACHE_LINE_SIZE_BITS-1:0] r_rsp_line;

   // Readies look at the registered count only; icache keeps one slot back for a same-cycle dcache push.
   always_comb begin
      dcache_req_ready_o = (w_count < CNT_W'(BUF_SIZE));
      if (dcache_req_valid_i) begin
         icache_req_ready_o = (w_count <= CNT_W'(BUF_SIZE - 2));
      end else begin
         icache_req_ready_o = (w_count < CNT_W'(BUF_SIZE));
      end
      w_d_push  = dcache_req_valid_i && dcache_req_ready_o;
      w_i_push  = icache_req_valid_i && icache_req_ready_o;
      w_d_entry = set_cache_id(dcache_req_i, DCACHE);
      w_i_entry = set_cache_id(icache_req_i, ICACHE);
   end

   segre_arb_fifo #(
      .BUF_SIZE (BUF_SIZE),
      .PTR_SIZE (PTR_SIZE)
   ) u_fifo (
      .i_clk    (clk_i),
      .i_rst    (rst_i),
      .i_push_a (w_d_push),
      .i_data_a (w_d_entry),
      .i_push_b (w_i_push),
      .i_data_b (w_i_entry),
      .i_pop    (w_pop),
      .o_head   (w_head),
      .o_count  (w_count),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   always_comb begin
      w_state_next    = r_state;
      w_pop           = 1'b0;
      w_rsp_fire      = 1'b0;
      w_mem_req_valid = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            w_mem_req_valid = !w_empty;
            if (w_mem_req_valid && mem_req_ready_i) begin
               w_pop        = 1'b1;
               w_state_next = ARB_WAIT_RSP;
            end else begin
               w_state_next = ARB_IDLE;
            end
         end
         ARB_WAIT_RSP: begin
            if (mem_rsp_valid_i) begin
               w_rsp_fire   = 1'b1;
               w_state_next = ARB_IDLE;
            end else begin
               w_state_next = ARB_WAIT_RSP;
            end
         end
         default: begin
            w_state_next = ARB_IDLE;
         end
      endcase
   end

   // The owner is captured at issue so the response can be steered without searching the FIFO.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state            <= ARB_IDLE;
         r_owner            <= ICACHE;
         r_icache_rsp_valid <= 1'b0;
         r_dcache_rsp_valid <= 1'b0;
         r_rsp_line         <= {CACHE_LINE_SIZE_BITS{1'b0}};
      end else begin
         r_state            <= w_state_next;
         r_owner            <= w_pop ? w_head.cache_id : r_owner;
         r_icache_rsp_valid <= w_rsp_fire && (r_owner == ICACHE);
         r_dcache_rsp_valid <= w_rsp_fire && (r_owner == DCACHE);
         r_rsp_line         <= w_rsp_fire ? mem_rsp_line_i : r_rsp_line;
      end
   end

   assign mem_req_valid_o    = w_mem_req_valid;
   assign mem_req_o          = w_head;
   assign icache_rsp_valid_o = r_icache_rsp_valid;
   assign dcache_rsp_valid_o = r_dcache_rsp_valid;
   assign rsp_line_o         = r_rsp_line;
   assign full_o             = w_full;
   assign empty_o            = w_empty;

`ifdef SEGRE_ARB_STATS_EN
   logic [31:0] r_stat_i;
   logic [31:0] r_stat_d;
   logic [31:0] r_stat_f;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stat_i <= 32'd0;
         r_stat_d <= 32'd0;
         r_stat_f <= 32'd0;
      end else begin
         r_stat_i <= (w_i_push && (r_stat_i != 32'hFFFF_FFFF)) ? r_stat_i + 32'd1 : r_stat_i;
         r_stat_d <= (w_d_push && (r_stat_d != 32'hFFFF_FFFF)) ? r_stat_d + 32'd1 : r_stat_d;
         r_stat_f <= (w_full && (icache_req_valid_i || dcache_req_valid_i) &&
                      (r_stat_f != 32'hFFFF_FFFF)) ? r_stat_f + 32'd1 : r_stat_f;
      end
   end

   assign stat_icache_reqs_o = r_stat_i;
   assign stat_dcache_reqs_o = r_stat_d;
   assign stat_full_cycles_o = r_stat_f;
`endif

   segre_mem_arbiter_chk u_chk (
      .i_clk           (clk_i),
      .i_rst           (rst_i),
      .i_state         (r_state),
      .i_mem_rsp_valid (mem_rsp_valid_i),
      .i_mem_req_valid (w_mem_req_valid),
      .i_mem_req_ready (mem_req_ready_i),
      .i_mem_req       (w_head)
   );

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Randomized bench for segre_mem_arbiter against a queue-based reference model;
// stats checks are compiled in with SEGRE_ARB_STATS_EN.
module tb_segre_mem_arbiter;
   import segre_pkg::*;

   typedef logic [255:0] val_t;
   localparam int unsigned LW   = CACHE_LINE_SIZE_BITS;
   localparam int          NBUF = ARB_BUF_SIZE;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           icache_req_valid_i, dcache_req_valid_i;
   cache_mem_req_t icache_req_i, dcache_req_i;
   logic           icache_req_ready_o, dcache_req_ready_o;
   logic           mem_req_valid_o, mem_req_ready_i, mem_rsp_valid_i;
   cache_mem_req_t mem_req_o;
   logic [LW-1:0]  mem_rsp_line_i, rsp_line_o;
   logic           icache_rsp_valid_o, dcache_rsp_valid_o, full_o, empty_o;
`ifdef SEGRE_ARB_STATS_EN
   logic [31:0]    stat_icache_reqs_o, stat_dcache_reqs_o, stat_full_cycles_o;
`endif

   segre_mem_arbiter dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .icache_req_valid_i (icache_req_valid_i),
      .icache_req_i       (icache_req_i),
      .icache_req_ready_o (icache_req_ready_o),
      .dcache_req_valid_i (dcache_req_valid_i),
      .dcache_req_i       (dcache_req_i),
      .dcache_req_ready_o (dcache_req_ready_o),
      .mem_req_valid_o    (mem_req_valid_o),
      .mem_req_o          (mem_req_o),
      .mem_req_ready_i    (mem_req_ready_i),
      .mem_rsp_valid_i    (mem_rsp_valid_i),
      .mem_rsp_line_i     (mem_rsp_line_i),
      .icache_rsp_valid_o (icache_rsp_valid_o),
      .dcache_rsp_valid_o (dcache_rsp_valid_o),
      .rsp_line_o         (rsp_line_o),
      .full_o             (full_o),
      .empty_o            (empty_o)
`ifdef SEGRE_ARB_STATS_EN
      ,
      .stat_icache_reqs_o (stat_icache_reqs_o),
      .stat_dcache_reqs_o (stat_dcache_reqs_o),
      .stat_full_cycles_o (stat_full_cycles_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Reference model state
   cache_mem_req_t q[$];
   logic           m_out;
   cache_id_e      m_owner;
   logic           e_irsp, e_drsp;
   logic [LW-1:0]  e_line;
   int unsigned    m_st_i, m_st_d, m_st_f;

   int             n_cmp = 0;
   int             n_err = 0;
   int             dut_irsp_cnt = 0;
   int             dut_drsp_cnt = 0;
   logic [31:0]    dut_issued[$];
   logic [31:0]    t4_addr[$];
   logic           last_d_acc;
   cache_mem_req_t z;
   logic           s_iv, s_dv, s_mr, s_rv;
   int             saved_i, saved_d;

   task automatic chk(input string tag, input val_t got, input val_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic cache_mem_req_t rand_req(input logic [31:0] addr);
      cache_mem_req_t r;
      r.addr     = addr;
      r.rd       = ($urandom_range(0, 1) == 0);
      r.wr       = !r.rd;
      r.data     = {$urandom, $urandom, $urandom, $urandom};
      r.cache_id = ($urandom_range(0, 1) == 0) ? ICACHE : DCACHE;
      return r;
   endfunction

   function automatic logic [LW-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic cache_mem_req_t mk_req(input logic [31:0] addr, input logic wr);
      cache_mem_req_t r;
      r      = rand_req(addr);
      r.rd   = !wr;
      r.wr   = wr;
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      m_out   = 1'b0;
      m_owner = ICACHE;
      e_irsp  = 1'b0;
      e_drsp  = 1'b0;
      e_line  = '0;
      m_st_i  = 0;
      m_st_d  = 0;
      m_st_f  = 0;
   endtask

   // One clock cycle: drive at posedge+1, check and advance the model at negedge.
   task automatic step(input logic iv, input cache_mem_req_t ir, input logic dv, input cache_mem_req_t dr,
                       input logic mr, input logic rv, input logic [LW-1:0] rl);
      int             cnt;
      logic           exp_dr, exp_ir, exp_mv;
      cache_mem_req_t e;
      icache_req_valid_i = iv;
      icache_req_i       = ir;
      dcache_req_valid_i = dv;
      dcache_req_i       = dr;
      mem_req_ready_i    = mr;
      mem_rsp_valid_i    = rv;
      mem_rsp_line_i     = rl;
      @(negedge clk_i);
      cnt    = q.size();
      exp_dr = (cnt < NBUF);
      exp_ir = dv ? (cnt <= NBUF - 2) : (cnt < NBUF);
      exp_mv = !m_out && (cnt > 0);
      chk("d_ready", val_t'(dcache_req_ready_o), val_t'(exp_dr));
      chk("i_ready", val_t'(icache_req_ready_o), val_t'(exp_ir));
      chk("full", val_t'(full_o), val_t'(cnt == NBUF));
      chk("empty", val_t'(empty_o), val_t'(cnt == 0));
      chk("mem_valid", val_t'(mem_req_valid_o), val_t'(exp_mv));
      if (exp_mv) chk("mem_req", val_t'(mem_req_o), val_t'(q[0]));
      chk("i_rsp", val_t'(icache_rsp_valid_o), val_t'(e_irsp));
      chk("d_rsp", val_t'(dcache_rsp_valid_o), val_t'(e_drsp));
      if (e_irsp || e_drsp) chk("rsp_line", val_t'(rsp_line_o), val_t'(e_line));
`ifdef SEGRE_ARB_STATS_EN
      chk("stat_i", val_t'(stat_icache_reqs_o), val_t'(m_st_i));
      chk("stat_d", val_t'(stat_dcache_reqs_o), val_t'(m_st_d));
      chk("stat_f", val_t'(stat_full_cycles_o), val_t'(m_st_f));
`endif
      if (icache_rsp_valid_o) dut_irsp_cnt++;
      if (dcache_rsp_valid_o) dut_drsp_cnt++;
      if (mem_req_valid_o && mr) dut_issued.push_back(mem_req_o.addr);
      e_irsp = 1'b0;
      e_drsp = 1'b0;
      if (m_out && rv) begin
         e_irsp = (m_owner == ICACHE);
         e_drsp = (m_owner == DCACHE);
         e_line = rl;
         m_out  = 1'b0;
      end else if (exp_mv && mr) begin
         m_owner = q[0].cache_id;
         void'(q.pop_front());
         m_out = 1'b1;
      end
      if (cnt == NBUF && (iv || dv)) m_st_f++;
      last_d_acc = dv && exp_dr;
      if (dv && exp_dr) begin
         e = dr;
         e.cache_id = DCACHE;
         q.push_back(e);
         m_st_d++;
      end
      if (iv && exp_ir) begin
         e = ir;
         e.cache_id = ICACHE;
         q.push_back(e);
         m_st_i++;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic serve();
      int budget = 300;
      while ((q.size() > 0 || m_out) && budget > 0) begin
         step(1'b0, z, 1'b0, z, 1'b1, m_out && ($urandom_range(0, 1) == 0), rand_line());
         budget--;
      end
      chk("drain_done", val_t'(q.size() == 0 && !m_out), val_t'(1'b1));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_mem_valid"}, val_t'(mem_req_valid_o), val_t'(1'b0));
      chk({tag, "_i_rsp"}, val_t'(icache_rsp_valid_o), val_t'(1'b0));
      chk({tag, "_d_rsp"}, val_t'(dcache_rsp_valid_o), val_t'(1'b0));
      chk({tag, "_line"}, val_t'(rsp_line_o), val_t'(0));
      chk({tag, "_full"}, val_t'(full_o), val_t'(1'b0));
      chk({tag, "_empty"}, val_t'(empty_o), val_t'(1'b1));
   endtask

   // Asserts reset mid-cycle; optionally pulses a stray response while reset is held.
   task automatic do_reset(input logic with_rsp);
      icache_req_valid_i = 1'b0;
      dcache_req_valid_i = 1'b0;
      mem_req_ready_i    = 1'b0;
      mem_rsp_valid_i    = 1'b0;
      mem_rsp_line_i     = rand_line();
      #2;
      rst_i = 1'b1;
      model_reset();
      #1;
      check_reset_outputs("rst");
      mem_rsp_valid_i = with_rsp;
      @(posedge clk_i);
      #1;
      mem_rsp_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      z = '0;
      icache_req_i = '0;
      dcache_req_i = '0;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      do_reset(1'b0);

      // 1: single icache read, response three cycles after issue
      step(1'b1, mk_req(32'h0000_1000, 1'b0), 1'b0, z, 1'b1, 1'b0, '0);
      step(1'b0, z, 1'b0, z, 1'b1, 1'b0, '0);
      step(1'b0, z, 1'b0, z, 1'b1, 1'b0, '0);
      step(1'b0, z, 1'b0, z, 1'b1, 1'b0, '0);
      step(1'b0, z, 1'b0, z, 1'b1, 1'b1, {16{8'hA5}});
      step(1'b0, z, 1'b0, z, 1'b1, 1'b0, '0);
      step(1'b0, z, 1'b0, z, 1'b1, 1'b0, '0);
      chk("t1_i_pulses", val_t'(dut_irsp_cnt), val_t'(1));
      chk("t1_d_pulses", val_t'(dut_drsp_cnt), val_t'(0));
      chk("t1_addr", val_t'(dut_issued[0]), val_t'(32'h0000_1000));

      // 2: same-cycle icache read and dcache write, dcache first
      dut_issued.delete();
      step(1'b1, mk_req(32'h0000_0100, 1'b0), 1'b1, mk_req(32'h0000_0200, 1'b1), 1'b1, 1'b0, '0);
      serve();
      chk("t2_count", val_t'(dut_issued.size()), val_t'(2));
      chk("t2_first", val_t'(dut_issued[0]), val_t'(32'h0000_0200));
      chk("t2_second", val_t'(dut_issued[1]), val_t'(32'h0000_0100));

      // 3: fill to 15, then both valid: only dcache goes in
      for (int k = 0; k < 15; k++) step(1'b0, z, 1'b1, rand_req(32'h3000 + k), 1'b0, 1'b0, '0);
      step(1'b1, rand_req(32'h3F00), 1'b1, rand_req(32'h3E00), 1'b0, 1'b0, '0);
      chk("t3_full", val_t'(full_o), val_t'(1'b1));
      chk("t3_d_ready", val_t'(dcache_req_ready_o), val_t'(1'b0));
      chk("t3_i_ready", val_t'(icache_req_ready_o), val_t'(1'b0));
      step(1'b1, rand_req(32'h3F00), 1'b1, rand_req(32'h3E01), 1'b0, 1'b0, '0);
      serve();

      // 4: 20 back-to-back dcache pushes with memory draining
      dut_issued.delete();
      t4_addr.delete();
      for (int k = 0; k < 200 && t4_addr.size() < 20; k++) begin
         step(1'b0, z, 1'b1, rand_req(32'h4000 + 32'(t4_addr.size()) * 32'd64), 1'b1,
              m_out && ($urandom_range(0, 2) == 0), rand_line());
         if (last_d_acc) t4_addr.push_back(32'h4000 + 32'(t4_addr.size()) * 32'd64);
      end
      serve();
      chk("t4_count", val_t'(dut_issued.size()), val_t'(20));
      for (int k = 0; k < 20 && k < dut_issued.size(); k++) chk("t4_order", val_t'(dut_issued[k]), val_t'(t4_addr[k]));

      // 5: reset while waiting for a response with five entries queued
      for (int k = 0; k < 6; k++) step(1'b0, z, 1'b1, rand_req(32'h5000 + k), 1'b0, 1'b0, '0);
      step(1'b0, z, 1'b0, z, 1'b1, 1'b0, '0);
      chk("t5_queued", val_t'(q.size()), val_t'(5));
      saved_i = dut_irsp_cnt;
      saved_d = dut_drsp_cnt;
      do_reset(1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, z, 1'b0, z, 1'b1, 1'b0, '0);
      chk("t5_no_rsp", val_t'((dut_irsp_cnt - saved_i) + (dut_drsp_cnt - saved_d)), val_t'(0));

      // Random traffic: fast memory first, then slow memory to reach full
      for (int c = 0; c < 600; c++) begin
         s_mr = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
         s_iv = ($urandom_range(0, 1) == 0);
         s_dv = ($urandom_range(0, 1) == 0);
         s_rv = m_out && ($urandom_range(0, 2) == 0);
         step(s_iv, rand_req($urandom), s_dv, rand_req($urandom), s_mr, s_rv, rand_line());
      end
      serve();

`ifdef SEGRE_ARB_STATS_EN
      // 6: statistics counters
      do_reset(1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, rand_req(32'h6000 + k), 1'b0, z, 1'b0, 1'b0, '0);
      for (int k = 0; k < 2; k++) step(1'b0, z, 1'b1, rand_req(32'h6100 + k), 1'b0, 1'b0, '0);
      step(1'b0, z, 1'b0, z, 1'b0, 1'b0, '0);
      chk("t6_stat_i", val_t'(stat_icache_reqs_o), val_t'(3));
      chk("t6_stat_d", val_t'(stat_dcache_reqs_o), val_t'(2));
      serve();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/segre_mem_arbiter.md
Name: segre_mem_arbiter

Overview:
- Sits between the icache/dcache miss logic and the single main-memory port.
- Queues cache_mem_req_t requests from both caches in one in-order FIFO of ARB_BUF_SIZE entries.
- Issues requests to memory one at a time and routes each response back to the originating cache by cache_id.
- Has one outstanding memory transaction at most; dcache wins same-cycle ties.

Parameters:
- BUF_SIZE, ARB_BUF_SIZE (16), FIFO depth; must be a power of two and at least 2.
- PTR_SIZE, ARB_PTR_SIZE (4), pointer width, $clog2(BUF_SIZE).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- icache_req_valid_i  in  1  icache request present.
- icache_req_i  in  $bits(cache_mem_req_t)  icache request; cache_id is ignored and forced to ICACHE on enqueue.
- icache_req_ready_o  out  1  icache request accepted this cycle when valid and ready are both high.
- dcache_req_valid_i  in  1  dcache request present.
- dcache_req_i  in  $bits(cache_mem_req_t)  dcache request; cache_id forced to DCACHE.
- dcache_req_ready_o  out  1  dcache accept.
- mem_req_valid_o  out  1  request to memory valid.
- mem_req_o  out  $bits(cache_mem_req_t)  FIFO head.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_rsp_valid_i  in  1  one-cycle response pulse; one pulse per request, for both rd and wr.
- mem_rsp_line_i  in  CACHE_LINE_SIZE_BITS  read data (don't-care for writes).
- icache_rsp_valid_o  out  1  response for icache.
- dcache_rsp_valid_o  out  1  response for dcache.
- rsp_line_o  out  CACHE_LINE_SIZE_BITS  registered response line, shared by both caches.
- full_o  out  1  count == BUF_SIZE.
- empty_o  out  1  count == 0.

Behaviour:
- Reset (async, rst_i=1):
  - wr_ptr, rd_ptr and count are 0; state is IDLE.
  - All *_valid_o are 0, rsp_line_o is 0, full_o is 0, empty_o is 1.
- Ready is computed from the registered count only, with no combinational dependence on the same-cycle pop:
  - dcache_req_ready_o = (count < BUF_SIZE).
  - icache_req_ready_o = (count <= BUF_SIZE-2) if dcache_req_valid_i, else (count < BUF_SIZE).
- Enqueue:
  - If both caches push in the same cycle, the dcache entry is written at wr_ptr and the icache entry at wr_ptr+1; wr_ptr advances by 2.
  - A single push advances wr_ptr by 1.
  - Pointers wrap modulo BUF_SIZE.
- FSM states: IDLE and WAIT_RSP.
  - IDLE: mem_req_valid_o = !empty. On valid && mem_req_ready_i, pop the head (rd_ptr+1, count-1), latch head.cache_id into owner_q, go to WAIT_RSP.
  - WAIT_RSP: mem_req_valid_o = 0. On mem_rsp_valid_i, register the line into rsp_line_o and pulse the owner's rsp_valid_o for exactly one cycle on the next edge, then go to IDLE.
- Latency:
  - Push to mem_req_valid_o is at least 1 cycle (the FIFO is registered).
  - Response to the cache arrives 1 cycle after mem_rsp_valid_i.
  - The next request issues no earlier than the cycle after the response is received.
- Count update per cycle: count_next = count + pushes - pop, where pushes is in {0,1,2} and pop is in {0,1}. Push and pop in the same cycle are legal.
- mem_req_o is held stable while mem_req_valid_o=1 and mem_req_ready_i=0.
- A mem_rsp_valid_i arriving in IDLE is ignored. This is protocol misuse; a simulation assertion flags it.
- Reset mid-transaction drops all queued and outstanding requests; no response pulse is generated afterwards.
- Ordering: issue order equals FIFO order, so a dcache store followed by an icache fetch of the same line is observed by memory in that order.

Optional Feature:
- Macro: SEGRE_ARB_STATS_EN.
- Defined: adds three 32-bit saturating counters, all cleared by reset:
  - stat_icache_reqs_o: accepted icache requests.
  - stat_dcache_reqs_o: accepted dcache requests.
  - stat_full_cycles_o: cycles with full_o=1 and any request valid.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- segre_pkg: cache_mem_req_t, cache_id_e, ARB_BUF_SIZE, ARB_PTR_SIZE and CACHE_LINE_SIZE_BITS, all existing. Add the new enum arb_state_e {ARB_IDLE, ARB_WAIT_RSP} to the package.
- Sub-module segre_arb_fifo: dual-write, single-read circular buffer holding the pointers and count, exposing count, full and empty. The arbiter top holds the FSM and response routing.

Test Plan:
1. Reset, then a single icache rd to addr 0x0000_1000; memory ready=1, response 3 cycles later with line 0xA5..A5 -> mem_req_o.cache_id=ICACHE; icache_rsp_valid_o pulses once with rsp_line_o=0xA5..A5; dcache_rsp_valid_o stays 0.
2. Same-cycle icache rd 0x100 and dcache wr 0x200 -> memory sees 0x200 (DCACHE, wr=1) first, then 0x100; responses route to dcache, then icache.
3. Fill 16 requests with mem_req_ready_i=0 -> full_o=1 and both readies 0. With count=15 and both caches valid -> only the dcache request is accepted and the icache request waits.
4. 20 back-to-back dcache pushes while memory drains, forcing rd_ptr/wr_ptr wrap past 15 -> all 20 addresses are issued in order with none lost or duplicated.
5. rst_i asserted while in WAIT_RSP with 5 entries queued -> all outputs return to reset values immediately; a later mem_rsp_valid_i produces no cache response.
6. With SEGRE_ARB_STATS_EN defined, 3 icache and 2 dcache requests -> stat_icache_reqs_o=3 and stat_dcache_reqs_o=2.
